rca_pipe: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. It generalises the 4-bit ripple adder to WIDTH bits, split into STAGES registered carry slices. It adds an add/subtract mode, a signed-overflow flag and valid/ready handshakes on both sides. It sits between operand producers and result consumers in datapaths where a full-width ripple cannot close timing in one cycle.

---
 rtl/rca_pipe.sv | 112 +++++++++++
 tb/tb_rca_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder/subtractor with valid/ready handshakes
module rca_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int W = WIDTH / STAGES;

  // Whole pipe moves together; an unconsumed result freezes every stage.
  logic adv;

  // Per-stage registered state: valid, partial sum, pending operand bits, slice carry.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic              msbc_q;

  // Inputs seen by each slice: the capture port for slice 0, the previous register otherwise.
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] c_src;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];

  // Slice results.
  logic [W-1:0]      slice_s [STAGES];
  logic [STAGES-1:0] cy_d;
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              msbc_d;

  assign adv      = !OUT_VALID || OUT_READY;
  assign IN_READY = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [W:0] slice;

    if (k == 0) begin : g_head
      // B is inverted once at capture; SUB forces the initial carry to 1.
      assign v_src[0] = IN_VALID;
      assign a_src[0] = A;
      assign b_src[0] = SUB ? ~B : B;
      assign c_src[0] = SUB | Cin;
      assign s_src[0] = '0;
    end else begin : g_tail
      assign v_src[k] = vld_q[k-1];
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign c_src[k] = cy_q[k-1];
      assign s_src[k] = sum_q[k-1];
    end

    assign slice      = {1'b0, a_src[k][k*W +: W]} + {1'b0, b_src[k][k*W +: W]} + {{W{1'b0}}, c_src[k]};
    assign slice_s[k] = slice[W-1:0];
    assign cy_d[k]    = slice[W];
  end

  // Merge each slice's fresh bits into the partial sum carried down the pipe.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]           = s_src[k];
      sum_d[k][k*W +: W] = slice_s[k];
    end
  end

  // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
  assign msbc_d = sum_d[STAGES-1][WIDTH-1] ^ a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1];

  // Pipeline registers: cleared on reset, shifted together on adv, otherwise held.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vld_q  <= '0;
      cy_q   <= '0;
      msbc_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (adv) begin
      msbc_q <= msbc_d;
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= v_src[k];
        cy_q[k]  <= cy_d[k];
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_src[k];
        b_q[k]   <= b_src[k];
      end
    end
  end

  assign OUT_VALID = vld_q[STAGES-1];
  assign S         = sum_q[STAGES-1];
  assign Cout      = cy_q[STAGES-1];
  assign OVF       = cy_q[STAGES-1] ^ msbc_q;

endmodule

// File: tb/tb_rca_pipe.sv
// tb/tb_rca_pipe.sv - self-checking bench for rca_pipe
module tb_rca_pipe;

  int checks   = 0;
  int failures = 0;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        IN_VALID, IN_READY, Cin, SUB, OUT_VALID, OUT_READY, Cout, OVF;
  logic [15:0] A, B, S;

  always #5 CLK = ~CLK;

  rca_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .Cin(Cin), .SUB(SUB),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .S(S), .Cout(Cout), .OVF(OVF)
  );

  // Sweep instances share one operand stream, truncated to each width.
  logic        sw_v, sw_cin, sw_sub, sw_ordy;
  logic [63:0] sw_a, sw_b;
  logic [3:0]  sw_ir, sw_ov, sw_c, sw_o;
  logic [7:0]  sw_s0, sw_s1;
  logic [31:0] sw_s2;
  logic [63:0] sw_s3;

  rca_pipe #(.WIDTH(8), .STAGES(1)) sw0 (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(sw_v), .IN_READY(sw_ir[0]),
    .A(sw_a[7:0]), .B(sw_b[7:0]), .Cin(sw_cin), .SUB(sw_sub),
    .OUT_VALID(sw_ov[0]), .OUT_READY(sw_ordy), .S(sw_s0), .Cout(sw_c[0]), .OVF(sw_o[0])
  );
  rca_pipe #(.WIDTH(8), .STAGES(8)) sw1 (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(sw_v), .IN_READY(sw_ir[1]),
    .A(sw_a[7:0]), .B(sw_b[7:0]), .Cin(sw_cin), .SUB(sw_sub),
    .OUT_VALID(sw_ov[1]), .OUT_READY(sw_ordy), .S(sw_s1), .Cout(sw_c[1]), .OVF(sw_o[1])
  );
  rca_pipe #(.WIDTH(32), .STAGES(4)) sw2 (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(sw_v), .IN_READY(sw_ir[2]),
    .A(sw_a[31:0]), .B(sw_b[31:0]), .Cin(sw_cin), .SUB(sw_sub),
    .OUT_VALID(sw_ov[2]), .OUT_READY(sw_ordy), .S(sw_s2), .Cout(sw_c[2]), .OVF(sw_o[2])
  );
  rca_pipe #(.WIDTH(64), .STAGES(16)) sw3 (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(sw_v), .IN_READY(sw_ir[3]),
    .A(sw_a), .B(sw_b), .Cin(sw_cin), .SUB(sw_sub),
    .OUT_VALID(sw_ov[3]), .OUT_READY(sw_ordy), .S(sw_s3), .Cout(sw_c[3]), .OVF(sw_o[3])
  );

  function automatic void chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endfunction

  // Reference: plain unsigned arithmetic for S/Cout, true signed range test for OVF.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub,
                                output logic [63:0] s, output logic c, output logic o);
    logic [63:0]        m;
    logic [64:0]        ua, ub, full;
    logic signed [66:0] sa, sb, ci, r, mx, mn;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ua = {1'b0, a & m};
    ub = {1'b0, b & m};
    if (sub) begin
      full = ua - ub;
      c    = (ua >= ub);
    end else begin
      full = ua + ub + {64'd0, cin};
      c    = full[w];
    end
    s  = full[63:0] & m;
    sa = $signed({3'b000, a & m});
    sb = $signed({3'b000, b & m});
    if (a[w-1]) sa = sa - (67'sd1 <<< w);
    if (b[w-1]) sb = sb - (67'sd1 <<< w);
    ci = cin ? 67'sd1 : 67'sd0;
    r  = sub ? (sa - sb) : (sa + sb + ci);
    mx = (67'sd1 <<< (w - 1)) - 67'sd1;
    mn = -(67'sd1 <<< (w - 1));
    o  = (r > mx) || (r < mn);
  endfunction

  // Main compare process: scoreboard of accepted beats, handshake and hold checks.
  logic        hold;
  logic [15:0] hold_s;
  logic        hold_c, hold_o;
  logic [65:0] exp_q [$];

  always @(negedge CLK) begin
    logic [63:0] es;
    logic        ec, eo;
    logic [65:0] e;
    if (!RSTn) begin
      chk("reset_state", {OUT_VALID, IN_READY, Cout, OVF, S}, {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
      exp_q.delete();
      hold = 1'b0;
    end else begin
      chk("in_ready", IN_READY, !OUT_VALID || OUT_READY);
      if (hold) chk("hold_stable", {OUT_VALID, S, Cout, OVF}, {1'b1, hold_s, hold_c, hold_o});
      if (OUT_VALID) begin
        if (exp_q.size() == 0) begin
          chk("out_expected", exp_q.size(), 1);
        end else begin
          e = exp_q[0];
          chk("result", {48'd0, S, Cout, OVF}, e);
          if (OUT_READY) void'(exp_q.pop_front());
        end
      end
      hold   = OUT_VALID && !OUT_READY;
      hold_s = S;
      hold_c = Cout;
      hold_o = OVF;
      if (IN_VALID && IN_READY) begin
        model(16, {48'd0, A}, {48'd0, B}, Cin, SUB, es, ec, eo);
        exp_q.push_back({es, ec, eo});
      end
    end
  end

  task automatic send_one(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          input logic [15:0] xs, input logic xc, input logic xo);
    logic [63:0] ms;
    logic        mc, mo;
    int          lat;
    model(16, {48'd0, a}, {48'd0, b}, ci, sb, ms, mc, mo);
    chk({nm, "_model"}, {ms, mc, mo}, {48'd0, xs, xc, xo});
    A = a; B = b; Cin = ci; SUB = sb; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    lat = 1;
    while (!OUT_VALID && lat < 12) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_dut"}, {OUT_VALID, S, Cout, OVF}, {1'b1, xs, xc, xo});
    @(posedge CLK); #1;
  endtask

  localparam int NSW = 1000;
  logic [63:0] ha [NSW];
  logic [63:0] hb [NSW];
  logic        hc [NSW];
  logic        hs [NSW];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t, n_acc, n_del;
    logic        acc;
    int          wj, sj;
    logic [63:0] gs, es;
    logic        ec, eo, ev;

    RSTn = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; Cin = 1'b0; SUB = 1'b0; OUT_READY = 1'b1;
    sw_v = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_ordy = 1'b1;
    #1 RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;

    send_one("basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    send_one("ripple",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("posovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_one("sub",     16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_one("subovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Streaming: 20 back-to-back beats, consumer stalls for cycles 10..12.
    t = 0; n_acc = 0; n_del = 0;
    A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); SUB = 1'($urandom);
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    while (n_del < 20 && t < 100) begin
      @(negedge CLK);
      acc = IN_VALID && IN_READY;
      if (t >= 10 && t <= 12) chk("stall_in_ready", {OUT_VALID, IN_READY}, 2'b10);
      if (OUT_VALID && OUT_READY) n_del++;
      if (acc) n_acc++;
      t++;
      @(posedge CLK); #1;
      OUT_READY = !(t >= 10 && t <= 12);
      if (n_acc >= 20) begin
        IN_VALID = 1'b0;
      end else if (acc) begin
        A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); SUB = 1'($urandom);
      end
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    chk("stream_cycles", t, 27);
    chk("stream_accepts", n_acc, 20);

    // Reset while three beats are in flight.
    repeat (3) begin
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); SUB = 1'($urandom);
      IN_VALID = 1'b1;
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    RSTn = 1'b0;
    #1;
    chk("midreset_clear", {OUT_VALID, S, IN_READY}, {1'b0, 16'h0000, 1'b1});
    @(posedge CLK); #1;
    RSTn = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      chk("no_stale_out", OUT_VALID, 1'b0);
    end
    @(posedge CLK); #1;
    send_one("postrst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Parameter sweep, full rate, random add/sub mix.
    for (int i = 0; i < NSW; i++) begin
      ha[i] = {$urandom, $urandom};
      hb[i] = {$urandom, $urandom};
      hc[i] = 1'($urandom);
      hs[i] = 1'($urandom);
    end
    for (int tt = 0; tt < NSW + 17; tt++) begin
      if (tt < NSW) begin
        sw_v = 1'b1; sw_a = ha[tt]; sw_b = hb[tt]; sw_cin = hc[tt]; sw_sub = hs[tt];
      end else begin
        sw_v = 1'b0;
      end
      @(negedge CLK);
      for (int j = 0; j < 4; j++) begin
        case (j)
          0:       begin wj = 8;  sj = 1;  gs = {56'd0, sw_s0}; end
          1:       begin wj = 8;  sj = 8;  gs = {56'd0, sw_s1}; end
          2:       begin wj = 32; sj = 4;  gs = {32'd0, sw_s2}; end
          default: begin wj = 64; sj = 16; gs = sw_s3;          end
        endcase
        ev = (tt >= sj) && (tt - sj < NSW);
        if (sw_ov[j] !== ev || sw_ir[j] !== 1'b1) begin
          chk($sformatf("sweep%0d_valid_t%0d", j, tt), {sw_ov[j], sw_ir[j]}, {ev, 1'b1});
        end else if (ev) begin
          model(wj, ha[tt-sj], hb[tt-sj], hc[tt-sj], hs[tt-sj], es, ec, eo);
          chk($sformatf("sweep%0d_data_t%0d", j, tt), {gs, sw_c[j], sw_o[j]}, {es, ec, eo});
        end else begin
          chk($sformatf("sweep%0d_idle_t%0d", j, tt), sw_ov[j], 1'b0);
        end
      end
      @(posedge CLK); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
